// File: rtl/qed_replay_buf_pkg.sv
// Shared definitions for the QED replay buffer: mode encodings, RV32 opcodes,
// register-field positions and opcode-format decode helpers.
package qed_replay_buf_pkg;

    // QED mode encodings driven by the mode state machine
    typedef enum logic [2:0] {
        ORIGINAL_MODE = 3'd0,
        WAIT1_MODE    = 3'd1,
        DUP_MODE      = 3'd2,
        WAIT2_MODE    = 3'd3,
        CHECK_MODE    = 3'd4
    } qed_mode_e;

    // RV32 major opcodes
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;

    // Register field positions (each field is 5 bits wide)
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    // Width of the issued-but-unretired counter
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } rv_fmt_e;

    // Which register fields a format carries
    typedef struct packed {
        logic rd;
        logic rs1;
        logic rs2;
    } reg_fields_t;

    // Opcode to instruction format; unknown/system opcodes are left untouched
    function automatic rv_fmt_e opc_format(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_AMO:              return FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: return FMT_I;
            OPC_STORE:                    return FMT_S;
            OPC_BRANCH:                   return FMT_B;
            OPC_LUI, OPC_AUIPC:           return FMT_U;
            OPC_JAL:                      return FMT_J;
            default:                      return FMT_NONE;
        endcase
    endfunction

    // Register fields present in each format
    function automatic reg_fields_t fmt_fields(input rv_fmt_e f);
        reg_fields_t r;
        r = '0;
        case (f)
            FMT_R: begin r.rd = 1'b1; r.rs1 = 1'b1; r.rs2 = 1'b1; end
            FMT_I: begin r.rd = 1'b1; r.rs1 = 1'b1; end
            FMT_S: begin r.rs1 = 1'b1; r.rs2 = 1'b1; end
            FMT_B: begin r.rs1 = 1'b1; r.rs2 = 1'b1; end
            FMT_U: r.rd = 1'b1;
            FMT_J: r.rd = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Control-transfer opcodes close a segment instead of being recorded
    function automatic logic is_ctrl_op(input logic [6:0] opc);
        return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
    endfunction

endpackage

// File: rtl/qed_reg_remap.sv
// Combinational register remap: moves every nonzero rd/rs1/rs2 field present
// in the instruction's format into the duplicate register bank.
module qed_reg_remap
    import qed_replay_buf_pkg::*;
#(
    parameter int IW         = 32,
    parameter int REG_OFFSET = 16
) (
    input  logic [IW-1:0] instr,
    output logic [IW-1:0] remapped
);

    reg_fields_t fld;

    // x0 is hard-wired zero and must stay x0 in the duplicate stream
    function automatic logic [4:0] bump(input logic [4:0] f);
        return (f == 5'd0) ? f : f + 5'(REG_OFFSET);
    endfunction

    // Patch only the fields the opcode format actually defines; immediates stay intact
    always_comb begin
        fld      = fmt_fields(opc_format(instr[6:0]));
        remapped = instr;
        if (fld.rd)  remapped[RD_LSB  +: 5] = bump(instr[RD_LSB  +: 5]);
        if (fld.rs1) remapped[RS1_LSB +: 5] = bump(instr[RS1_LSB +: 5]);
        if (fld.rs2) remapped[RS2_LSB +: 5] = bump(instr[RS2_LSB +: 5]);
    end

endmodule

// File: rtl/qed_replay_buf.sv
// QED instruction-side replay buffer. ORIGINAL mode forwards fetched
// instructions and records non-branches; DUP mode replays the recorded
// segment with registers remapped. Produces is_branch and pipeline_empty
// for the QED mode state machine.
module qed_replay_buf
    import qed_replay_buf_pkg::*;
#(
    parameter int IW         = 32,
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int REG_OFFSET = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    mode,
    input  logic          ifu_valid,
    input  logic [IW-1:0] ifu_instr,
    output logic          ifu_ready,
    output logic          exe_valid,
    output logic [IW-1:0] exe_instr,
    input  logic          exe_ready,
    input  logic          exe_retire,
    output logic          is_branch,
    output logic          pipeline_empty,
    output logic [AW:0]   seg_len
);

    localparam int SLW = AW + 1;

    logic [IW-1:0]    rbuf [DEPTH];
    logic [SLW-1:0]   rd_ptr;
    logic             seg_closed;
    logic             dup_done;
    logic [CNT_W-1:0] inflight;

    logic             in_orig, in_dup, in_check;
    logic             load_en, full;
    logic             accept, accept_ctrl, record, force_close;
    logic             dup_avail, dup_issue, dup_last, dup_empty;
    logic             br_pulse, exe_hs;
    logic [IW-1:0]    replay_raw, replay_instr;

    assign in_orig  = (mode == ORIGINAL_MODE);
    assign in_dup   = (mode == DUP_MODE);
    assign in_check = (mode == CHECK_MODE);

    // Output register can take a new instruction when empty or draining
    assign load_en = !exe_valid || exe_ready;
    assign full    = (seg_len == SLW'(DEPTH));

    // Full buffer also blocks accept so a record can never overflow; the
    // forced close below then ends the segment on the following cycle.
    assign ifu_ready   = rst && in_orig && !seg_closed && !full && load_en;
    assign accept      = ifu_valid && ifu_ready;
    assign accept_ctrl = accept && is_ctrl_op(ifu_instr[6:0]);
    assign record      = accept && !accept_ctrl;
    assign force_close = in_orig && !seg_closed && full && !accept;

    // Replay runs while entries remain; an empty (or already consumed)
    // segment still owes the state machine its one closing pulse.
    assign dup_avail = (rd_ptr < seg_len);
    assign dup_issue = in_dup && !dup_done && dup_avail && load_en;
    assign dup_last  = dup_issue && (rd_ptr == seg_len - SLW'(1));
    assign dup_empty = in_dup && !dup_done && !dup_avail;

    assign br_pulse = accept_ctrl || force_close || dup_last || dup_empty;
    assign exe_hs   = exe_valid && exe_ready;

    assign pipeline_empty = (inflight == '0) && !exe_valid;

    assign replay_raw = rbuf[rd_ptr[AW-1:0]];

    qed_reg_remap #(
        .IW         (IW),
        .REG_OFFSET (REG_OFFSET)
    ) u_remap (
        .instr    (replay_raw),
        .remapped (replay_instr)
    );

    // Segment storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (record) rbuf[seg_len[AW-1:0]] <= ifu_instr;
    end

    // Output stage: one register fed by fetch in ORIGINAL or by replay in DUP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_valid <= 1'b0;
            exe_instr <= '0;
        end else if (load_en) begin
            exe_valid <= accept || dup_issue;
            if (accept)         exe_instr <= ifu_instr;
            else if (dup_issue) exe_instr <= replay_instr;
        end
    end

    // Segment bookkeeping: length, closure, replay pointer and segment-close pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_len    <= '0;
            seg_closed <= 1'b0;
            rd_ptr     <= '0;
            dup_done   <= 1'b0;
            is_branch  <= 1'b0;
        end else begin
            is_branch <= br_pulse;
            if (record) seg_len <= seg_len + SLW'(1);
            if (accept_ctrl || force_close) seg_closed <= 1'b1;
            if (dup_issue) rd_ptr <= rd_ptr + SLW'(1);
            // One closing pulse per DUP phase; re-armed once the phase ends
            if (!in_dup)                   dup_done <= 1'b0;
            else if (dup_last || dup_empty) dup_done <= 1'b1;
            if (in_check) begin
                seg_len    <= '0;
                rd_ptr     <= '0;
                seg_closed <= 1'b0;
            end
        end
    end

    // Issued-but-unretired count; simultaneous issue and retire cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else if (exe_hs && !exe_retire) begin
            if (inflight != '1) inflight <= inflight + CNT_W'(1);
        end else if (!exe_hs && exe_retire) begin
            if (inflight != '0) inflight <= inflight - CNT_W'(1);
        end
    end

endmodule
